key_scan_led_mux: RTL and testbench

Parametrised successor to the front-panel keypad/LED scanner. It drives a multiplexed scan address, samples the key return lines and debounces one key at a time. Press and release events go into a small event queue that raises an active-low interrupt to the host. The same scan address also time-multiplexes a serial LED data line. It sits between the front-panel decoder (HC138/HC147-style) and the host register interface.

---
 rtl/key_scan_pkg.sv | 39 +++
 rtl/key_event_fifo.sv | 63 ++++++
 rtl/key_scan_led_mux.sv | 249 ++++++++++++++++++++++++
 tb/tb_key_scan_led_mux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared types and helpers for the key scanner / LED multiplexer
//
// Purpose : VKEY event field positions, scanner FSM state type, Gray-code
//           conversion and lowest-set-bit priority encoder.
// Ports   : none (package)

package key_scan_pkg;

  // Event word layout presented on VKEY
  localparam int VKEY_W    = 16;
  localparam int KEV_BIT   = 15;  // 1 = press, 0 = release
  localparam int SENSE_LSB = 8;   // 4-bit sense (return line) index
  localparam int SENSE_W   = 4;
  localparam int SCAN_LSB  = 0;   // 8-bit scan line index
  localparam int SCAN_W    = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } scan_state_e;

  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Index of the lowest set bit; 0 for an all-zero input (callers qualify
  // with a separate any-bit-set test).
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - small event queue between the key scanner and the host
//
// Purpose : power-of-two deep FIFO. A push while full is accepted only when
//           a pop is accepted in the same cycle; a pop while empty is ignored.
// Ports   : clk_i, rst_i (sync, active-high)
//           push_i, data_i  - write request and data
//           pop_i           - read strobe
//           full_o, empty_o - occupancy flags
//           head_o          - oldest entry (undefined while empty)

module key_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign head_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/key_scan_led_mux.sv
// rtl/key_scan_led_mux.sv - multiplexed keypad scanner with debounce, event queue and LED mux
//
// Purpose : steps a scan address through N_SCAN lines, debounces one key at a
//           time, queues press/release events for the host and serialises
//           the LED pattern on the same scan address.
// Ports   : CLK, RST (sync, active-high)
//           KB       - key return lines, active-high, already synchronised
//           KD       - scan address to the decoder (Gray or binary)
//           LED      - LED pattern, bit i shown while scanning line i
//           LED_OUT  - multiplexed LED data
//           INT      - active-low, low while an event is queued
//           VKEY     - queue head {press, 000, sense[3:0], scan[7:0]}, 0 when empty
//           VKEY_ACK - pop strobe
//           OVF      - sticky event-dropped flag, cleared by an accepted pop

module key_scan_led_mux
  import key_scan_pkg::*;
#(
  parameter  int CLK_DIV_W  = 13,
  parameter  int N_SCAN     = 8,
  parameter  int N_SENSE    = 5,
  parameter  int DEBOUNCE   = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int GRAY_SCAN  = 1,
  parameter  int REL_EVT    = 1,
  localparam int SW         = $clog2(N_SCAN)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_SENSE-1:0] KB,
  output logic [SW-1:0]      KD,
  input  logic [N_SCAN-1:0]  LED,
  output logic               LED_OUT,
  output logic               INT,
  output logic [15:0]        VKEY,
  input  logic               VKEY_ACK,
  output logic               OVF
);

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  // Scan timing
  logic [CLK_DIV_W-1:0] div_q, div_d;
  logic [SW-1:0]        idx_q, idx_d, idx_nxt;
  logic [SW-1:0]        kd_q, kd_d;
  logic                 led_q, led_d;
  logic                 tick;

  // Debounce FSM
  scan_state_e          state_q, state_d;
  logic [SW-1:0]        line_q, line_d;
  logic [3:0]           code_q, code_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           cnt_inc;
  logic                 kb_any;
  logic [3:0]           kb_code;
  logic                 visit;

  // Event path
  logic                 push;
  logic                 push_press;
  logic [SW-1:0]        evt_line;
  logic [3:0]           evt_code;
  logic [VKEY_W-1:0]    evt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [VKEY_W-1:0]    fifo_head;
  logic                 pop_ok;
  logic                 ovf_q, ovf_d;

  // ---------------------------------------------------------------------
  // Divider and scan index. KB is sampled in the last cycle of each dwell,
  // which is the same edge that moves to the next line.
  // ---------------------------------------------------------------------
  assign tick    = &div_q;
  assign idx_nxt = (idx_q == SW'(N_SCAN - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    kd_d  = kd_q;
    led_d = led_q;
    if (tick) begin
      idx_d = idx_nxt;
      kd_d  = (GRAY_SCAN != 0) ? SW'(bin2gray(8'(idx_nxt))) : idx_nxt;
      led_d = LED[idx_nxt];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q <= '0;
      idx_q <= '0;
      kd_q  <= '0;
      led_q <= 1'b0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      kd_q  <= kd_d;
      led_q <= led_d;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce FSM. Only the captured line is watched once a key is being
  // tracked; everything else is ignored until we are back in IDLE.
  // ---------------------------------------------------------------------
  assign kb_any  = |KB;
  assign kb_code = lowest_set(16'(KB));
  assign visit   = (idx_q == line_q);
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_press = 1'b0;
    evt_line   = line_q;
    evt_code   = code_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (kb_any) begin
            line_d   = idx_q;
            code_d   = kb_code;
            cnt_d    = 4'd1;
            evt_line = idx_q;
            evt_code = kb_code;
            // A debounce count of one accepts the press on the capture visit.
            if (DB == 4'd1) begin
              push       = 1'b1;
              push_press = 1'b1;
              state_d    = HELD;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (visit) begin
            if (kb_any && (kb_code == code_q)) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DB) begin
                push       = 1'b1;
                push_press = 1'b1;
                state_d    = HELD;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end
        HELD: begin
          if (visit && !kb_any) begin
            cnt_d = 4'd1;
            if (DB == 4'd1) begin
              push    = (REL_EVT != 0);
              state_d = IDLE;
            end else begin
              state_d = REL_DB;
            end
          end
        end
        REL_DB: begin
          if (visit) begin
            if (!kb_any) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DB) begin
                push    = (REL_EVT != 0);
                state_d = IDLE;
              end
            end else begin
              state_d = HELD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      line_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    evt                             = '0;
    evt[KEV_BIT]                    = push_press;
    evt[SENSE_LSB +: SENSE_W]       = evt_code;
    evt[SCAN_LSB +: SCAN_W]         = 8'(evt_line);
  end

  // ---------------------------------------------------------------------
  // Event queue and host-side flags
  // ---------------------------------------------------------------------
  key_event_fifo #(
    .WIDTH (VKEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .data_i  (evt),
    .pop_i   (VKEY_ACK),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign pop_ok = VKEY_ACK && !fifo_empty;

  // A pop wins over a same-cycle drop: when full, a pop frees the slot so
  // the push is not dropped anyway.
  always_comb begin
    ovf_d = ovf_q;
    if (pop_ok) begin
      ovf_d = 1'b0;
    end else if (push && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign KD      = kd_q;
  assign LED_OUT = led_q;
  assign INT     = fifo_empty;
  assign VKEY    = fifo_empty ? '0 : fifo_head;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_key_scan_led_mux.sv
// tb/tb_key_scan_led_mux.sv - directed self-checking bench for key_scan_led_mux

module tb_key_scan_led_mux;

  logic        clk;
  logic        rst;
  logic [4:0]  kb;
  logic [7:0]  led;
  logic        vkey_ack;

  logic [2:0]  kd0, kd1;
  logic        led_out0, led_out1;
  logic        int_n0, int_n1;
  logic [15:0] vkey0, vkey1;
  logic        ovf0, ovf1;

  int          n_vec;
  int          n_miss;
  int          idx;
  bit          first_dwell;
  logic        int_pre0;

  // Gray sequence and 8'hA5 bit pattern by scan index
  logic [2:0]  kd_tab  [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  logic        led_tab [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  key_scan_led_mux #(
    .CLK_DIV_W (2), .N_SCAN (8), .N_SENSE (5), .DEBOUNCE (3),
    .FIFO_DEPTH (4), .GRAY_SCAN (1), .REL_EVT (1)
  ) u_dut (
    .CLK (clk), .RST (rst), .KB (kb), .KD (kd0), .LED (led),
    .LED_OUT (led_out0), .INT (int_n0), .VKEY (vkey0),
    .VKEY_ACK (vkey_ack), .OVF (ovf0)
  );

  key_scan_led_mux #(
    .CLK_DIV_W (2), .N_SCAN (8), .N_SENSE (5), .DEBOUNCE (3),
    .FIFO_DEPTH (4), .GRAY_SCAN (1), .REL_EVT (0)
  ) u_dut_nr (
    .CLK (clk), .RST (rst), .KB (kb), .KD (kd1), .LED (led),
    .LED_OUT (led_out1), .INT (int_n1), .VKEY (vkey1),
    .VKEY_ACK (vkey_ack), .OVF (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    kb       = '0;
    vkey_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, " kd0"},      kd0,      0);
    check_eq({tag, " led_out0"}, led_out0, 0);
    check_eq({tag, " int0"},     int_n0,   1);
    check_eq({tag, " vkey0"},    vkey0,    0);
    check_eq({tag, " ovf0"},     ovf0,     0);
    check_eq({tag, " kd1"},      kd1,      0);
    check_eq({tag, " led_out1"}, led_out1, 0);
    check_eq({tag, " int1"},     int_n1,   1);
    check_eq({tag, " vkey1"},    vkey1,    0);
    check_eq({tag, " ovf1"},     ovf1,     0);
    rst         = 1'b0;
    idx         = 0;
    first_dwell = 1'b1;
  endtask

  // One scan dwell (4 clocks). KB held for the whole dwell, sampled on the
  // last edge. KD/LED_OUT checked in every cycle of the dwell.
  task automatic dwell(input logic [4:0] kbv, input bit ack_first, input bit ack_last);
    kb = kbv;
    for (int j = 0; j < 4; j++) begin
      check_eq("kd dwell", kd0, kd_tab[idx]);
      check_eq("led_out dwell", led_out0, first_dwell ? 1'b0 : led_tab[idx]);
      vkey_ack = (j == 0 && ack_first) || (j == 3 && ack_last);
      if (j == 3) int_pre0 = int_n0;
      @(posedge clk);
      @(negedge clk);
    end
    vkey_ack    = 1'b0;
    kb          = '0;
    idx         = (idx + 1) % 8;
    first_dwell = 1'b0;
  endtask

  // Run dwells until line has been visited nv times with pattern pat.
  task automatic visit_run(input int line, input logic [4:0] pat, input int nv, input bit ack_on_push);
    int seen;
    seen = 0;
    while (seen < nv) begin
      if (idx == line) begin
        seen++;
        dwell(pat, 1'b0, ack_on_push && (seen == nv));
      end else begin
        dwell(5'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic ack_dwell();
    dwell(5'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    idx      = 0;
    rst      = 1'b1;
    kb       = '0;
    led      = 8'hA5;
    vkey_ack = 1'b0;
    int_pre0 = 1'b1;
    repeat (2) @(posedge clk);
    do_reset("reset");

    // Free-run two revolutions: Gray scan sequence and LED mux
    for (int i = 0; i < 16; i++) dwell(5'b0, 1'b0, 1'b0);

    // Press on line 5, sense 2, three visits
    visit_run(5, 5'b00100, 3, 1'b0);
    check_eq("int before push", int_pre0, 1);
    check_eq("int0 after press", int_n0, 0);
    check_eq("vkey0 press", vkey0, 16'h8205);
    check_eq("int1 after press", int_n1, 0);
    check_eq("vkey1 press", vkey1, 16'h8205);
    ack_dwell();
    check_eq("int0 after pop", int_n0, 1);
    check_eq("vkey0 empty", vkey0, 0);
    check_eq("int1 after pop", int_n1, 1);

    // Release: only the REL_EVT=1 instance queues it
    visit_run(5, 5'b0, 3, 1'b0);
    check_eq("int0 release", int_n0, 0);
    check_eq("vkey0 release", vkey0, 16'h0205);
    check_eq("int1 no release", int_n1, 1);
    ack_dwell();
    check_eq("int0 release popped", int_n0, 1);
    check_eq("int1 ack on empty", int_n1, 1);
    check_eq("ovf1 ack on empty", ovf1, 0);

    // Aborted press: two pressed visits then a released one
    visit_run(5, 5'b00100, 2, 1'b0);
    visit_run(5, 5'b0, 1, 1'b0);
    check_eq("int0 aborted", int_n0, 1);
    check_eq("int1 aborted", int_n1, 1);

    // FSM back in IDLE: multi-bit return resolves to lowest bit
    visit_run(2, 5'b10110, 3, 1'b0);
    check_eq("vkey0 lowest bit", vkey0, 16'h8102);
    visit_run(2, 5'b0, 3, 1'b0);
    ack_dwell();
    check_eq("vkey0 second entry", vkey0, 16'h0102);
    check_eq("int1 after single pop", int_n1, 1);
    ack_dwell();
    check_eq("int0 drained", int_n0, 1);

    // Overflow: five events, depth four
    visit_run(1, 5'b01000, 3, 1'b0);
    visit_run(1, 5'b0, 3, 1'b0);
    visit_run(3, 5'b10000, 3, 1'b0);
    visit_run(3, 5'b0, 3, 1'b0);
    check_eq("ovf0 full no drop", ovf0, 0);
    visit_run(4, 5'b00001, 3, 1'b0);
    check_eq("ovf0 drop", ovf0, 1);
    check_eq("vkey0 head kept", vkey0, 16'h8301);
    check_eq("ovf1 no drop", ovf1, 0);
    check_eq("vkey1 head", vkey1, 16'h8301);
    ack_dwell();
    check_eq("vkey0 advance", vkey0, 16'h0301);
    check_eq("ovf0 cleared", ovf0, 0);
    check_eq("vkey1 advance", vkey1, 16'h8403);

    // Refill to full, then push and pop on the same edge
    visit_run(4, 5'b0, 3, 1'b0);
    check_eq("ovf0 refill", ovf0, 0);
    visit_run(6, 5'b00010, 3, 1'b1);
    check_eq("ovf0 push+pop full", ovf0, 0);
    check_eq("vkey0 push+pop head", vkey0, 16'h8403);
    check_eq("vkey1 push+pop head", vkey1, 16'h8004);
    ack_dwell();
    check_eq("vkey0 pop1", vkey0, 16'h0403);
    check_eq("vkey1 pop1", vkey1, 16'h8106);
    ack_dwell();
    check_eq("vkey0 pop2", vkey0, 16'h0004);
    ack_dwell();
    check_eq("vkey0 pop3", vkey0, 16'h8106);
    check_eq("int0 pop3", int_n0, 0);
    ack_dwell();
    check_eq("int0 pop4 empty", int_n0, 1);
    check_eq("vkey0 pop4 empty", vkey0, 0);

    // Two queued entries and line 7 in REL_DB, then reset
    visit_run(6, 5'b0, 3, 1'b0);
    visit_run(7, 5'b00001, 3, 1'b0);
    visit_run(7, 5'b0, 1, 1'b0);
    check_eq("int0 pre-reset", int_n0, 0);
    check_eq("vkey0 pre-reset", vkey0, 16'h0106);
    do_reset("mid reset");
    visit_run(7, 5'b0, 3, 1'b0);
    check_eq("int0 no event after reset", int_n0, 1);
    check_eq("int1 no event after reset", int_n1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
